// File: rtl/intra_pkg.sv
// Shared definitions for the luma 16x16 intra path: pixel type, mode codes,
// block geometry and the mode-decider FSM state encoding.
package intra_pkg;

    localparam int PIX_W     = 8;
    localparam int BLK       = 16;
    localparam int NPIX      = BLK * BLK;
    localparam int SAD_W     = 16;
    localparam int ROW_SAD_W = 12;

    typedef logic [PIX_W-1:0] pixel_t;
    typedef logic [1:0]       mode_t;

    localparam mode_t MODE_V  = 2'd0;
    localparam mode_t MODE_H  = 2'd1;
    localparam mode_t MODE_DC = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACCUM,
        ST_COMPARE,
        ST_DONE
    } state_e;

    // Raster index col + 16*row; with BLK=16 this is just a concatenation.
    function automatic logic [7:0] rasterIdx(input logic [3:0] row, input logic [3:0] col);
        return {row, col};
    endfunction

endpackage

// File: rtl/row_sad16.sv
// Combinational SAD of one 16-pixel row against the matching prediction row.
module row_sad16
    import intra_pkg::*;
(
    input  pixel_t                 orig_i [BLK],
    input  pixel_t                 pred_i [BLK],
    output logic [ROW_SAD_W-1:0]   sad_o
);

    logic signed [PIX_W:0] diff;
    logic [PIX_W-1:0]      mag;

    // 9-bit signed difference keeps the full -255..255 range before taking |x|.
    always_comb begin
        sad_o = '0;
        diff  = '0;
        mag   = '0;
        for (int i = 0; i < BLK; i++) begin
            diff  = $signed({1'b0, orig_i[i]}) - $signed({1'b0, pred_i[i]});
            mag   = diff[PIX_W] ? PIX_W'(-diff) : diff[PIX_W-1:0];
            sad_o = sad_o + ROW_SAD_W'(mag);
        end
    end

endmodule

// File: rtl/luma16x16_mode_decider.sv
// Chooses the cheapest of the V/H/DC luma 16x16 predictions by per-mode SAD
// against an original macroblock that streams in one row per cycle.
module luma16x16_mode_decider
    import intra_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  pixel_t            vpred   [NPIX],
    input  pixel_t            hpred   [NPIX],
    input  pixel_t            dcpred  [NPIX],
    input  logic              orig_valid,
    input  pixel_t            orig_row [BLK],
    output logic              orig_ready,
    output logic              busy,
    output logic              done,
    output logic [1:0]        best_mode,
    output logic [SAD_W-1:0]  best_sad,
    output logic [SAD_W-1:0]  sad_v,
    output logic [SAD_W-1:0]  sad_h,
    output logic [SAD_W-1:0]  sad_dc
);

    state_e            state_q;
    logic [3:0]        rowIdx_q;
    logic [SAD_W-1:0]  accV_q, accH_q, accDc_q;
    logic              origReady_q, busy_q, done_q;
    mode_t             bestMode_q;
    logic [SAD_W-1:0]  bestSad_q, sadV_q, sadH_q, sadDc_q;

    pixel_t            vPred_q  [NPIX];
    pixel_t            hPred_q  [NPIX];
    pixel_t            dcPred_q [NPIX];

    pixel_t            vRow [BLK];
    pixel_t            hRow [BLK];
    pixel_t            dcRow [BLK];
    logic [ROW_SAD_W-1:0] rowSadV, rowSadH, rowSadDc;

    mode_t             bestMode_d;
    logic [SAD_W-1:0]  bestSad_d;
    logic              accept;

    // Prediction snapshot: pure datapath storage, so it carries no reset.
    always_ff @(posedge clk) begin
        if (state_q == ST_IDLE && start) begin
            vPred_q  <= vpred;
            hPred_q  <= hpred;
            dcPred_q <= dcpred;
        end
    end

    always_comb begin
        for (int c = 0; c < BLK; c++) begin
            vRow[c]  = vPred_q[rasterIdx(rowIdx_q, 4'(c))];
            hRow[c]  = hPred_q[rasterIdx(rowIdx_q, 4'(c))];
            dcRow[c] = dcPred_q[rasterIdx(rowIdx_q, 4'(c))];
        end
    end

    row_sad16 u_sadV  (.orig_i(orig_row), .pred_i(vRow),  .sad_o(rowSadV));
    row_sad16 u_sadH  (.orig_i(orig_row), .pred_i(hRow),  .sad_o(rowSadH));
    row_sad16 u_sadDc (.orig_i(orig_row), .pred_i(dcRow), .sad_o(rowSadDc));

    // Strict less-than in V, H, DC order so ties favour the lower mode number.
    always_comb begin
        bestMode_d = MODE_V;
        bestSad_d  = accV_q;
        if (accH_q < bestSad_d) begin
            bestMode_d = MODE_H;
            bestSad_d  = accH_q;
        end
        if (accDc_q < bestSad_d) begin
            bestMode_d = MODE_DC;
            bestSad_d  = accDc_q;
        end
    end

    assign accept = orig_valid && origReady_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            rowIdx_q    <= '0;
            accV_q      <= '0;
            accH_q      <= '0;
            accDc_q     <= '0;
            origReady_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            bestMode_q  <= MODE_V;
            bestSad_q   <= '0;
            sadV_q      <= '0;
            sadH_q      <= '0;
            sadDc_q     <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q     <= ST_ACCUM;
                        rowIdx_q    <= '0;
                        accV_q      <= '0;
                        accH_q      <= '0;
                        accDc_q     <= '0;
                        origReady_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                ST_ACCUM: begin
                    if (accept) begin
                        accV_q   <= accV_q  + SAD_W'(rowSadV);
                        accH_q   <= accH_q  + SAD_W'(rowSadH);
                        accDc_q  <= accDc_q + SAD_W'(rowSadDc);
                        rowIdx_q <= rowIdx_q + 4'd1;
                        if (rowIdx_q == 4'(BLK - 1)) begin
                            state_q     <= ST_COMPARE;
                            origReady_q <= 1'b0;
                        end
                    end
                end
                ST_COMPARE: begin
                    bestMode_q <= bestMode_d;
                    bestSad_q  <= bestSad_d;
                    sadV_q     <= accV_q;
                    sadH_q     <= accH_q;
                    sadDc_q    <= accDc_q;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b1;
                    state_q    <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign orig_ready = origReady_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign best_mode  = bestMode_q;
    assign best_sad   = bestSad_q;
    assign sad_v      = sadV_q;
    assign sad_h      = sadH_q;
    assign sad_dc     = sadDc_q;

endmodule

// File: tb/tb_luma16x16_mode_decider.sv
// Directed bench for the luma 16x16 mode decider: hand-computed SADs, tie
// ordering, stalls, ignored restarts and asynchronous abort.
module tb_luma16x16_mode_decider;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [7:0]  vpred  [256];
    logic [7:0]  hpred  [256];
    logic [7:0]  dcpred [256];
    logic        orig_valid;
    logic [7:0]  orig_row [16];
    logic        orig_ready, busy, done;
    logic [1:0]  best_mode;
    logic [15:0] best_sad, sad_v, sad_h, sad_dc;

    logic [7:0]  origMem [16][16];
    int          checkCount = 0;
    int          passCount  = 0;
    int          doneCycle;
    logic        busyAtDone;
    int          doneSeen;

    always #5 clk = ~clk;

    luma16x16_mode_decider dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .vpred      (vpred),
        .hpred      (hpred),
        .dcpred     (dcpred),
        .orig_valid (orig_valid),
        .orig_row   (orig_row),
        .orig_ready (orig_ready),
        .busy       (busy),
        .done       (done),
        .best_mode  (best_mode),
        .best_sad   (best_sad),
        .sad_v      (sad_v),
        .sad_h      (sad_h),
        .sad_dc     (sad_dc)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        assert (observed === expected) passCount++;
        else $error("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    endtask

    // Pattern 1: V from top row 10*c; 2: H from left column 8*r; 3: flat 128;
    // 4: worst case 255 vs 0; 5: H and DC tie below V.
    task automatic setPattern(input int p);
        for (int r = 0; r < 16; r++) begin
            for (int c = 0; c < 16; c++) begin
                case (p)
                    1: begin
                        vpred[c+16*r] = 8'(10*c); hpred[c+16*r] = 8'd0;
                        dcpred[c+16*r] = 8'd75;   origMem[r][c] = 8'(10*c);
                    end
                    2: begin
                        vpred[c+16*r] = 8'd0;     hpred[c+16*r] = 8'(8*r);
                        dcpred[c+16*r] = 8'd60;   origMem[r][c] = 8'(8*r);
                    end
                    3: begin
                        vpred[c+16*r] = 8'd128;   hpred[c+16*r] = 8'd128;
                        dcpred[c+16*r] = 8'd128;  origMem[r][c] = 8'd128;
                    end
                    4: begin
                        vpred[c+16*r] = 8'd0;     hpred[c+16*r] = 8'd0;
                        dcpred[c+16*r] = 8'd255;  origMem[r][c] = 8'd255;
                    end
                    default: begin
                        vpred[c+16*r] = 8'd120;   hpred[c+16*r] = 8'd90;
                        dcpred[c+16*r] = 8'd110;  origMem[r][c] = 8'd100;
                    end
                endcase
            end
        end
    endtask

    // One full decision; cycle 0 is the start cycle, rows are driven from cycle 1.
    task automatic applyStimulus(input bit gapped, input bit midStart, input bit clobber,
                                 output int doneAt, output logic busyDone);
        int row;
        bit v;
        row      = 0;
        doneAt   = -1;
        busyDone = 1'bx;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            v = (row < 16) && (!gapped || (cyc % 2 == 1));
            orig_valid = v;
            for (int i = 0; i < 16; i++) orig_row[i] = (row < 16) ? origMem[row][i] : 8'd0;
            start = midStart && (cyc == 6);
            if (clobber && cyc == 3) begin
                for (int k = 0; k < 256; k++) begin
                    vpred[k] = 8'hFF; hpred[k] = 8'hFF; dcpred[k] = 8'hFF;
                end
            end
            @(posedge clk); #1;
            if (v) row++;
            if (done === 1'b1) begin
                doneAt   = cyc + 1;
                busyDone = busy;
                break;
            end
        end
        orig_valid = 1'b0;
        start      = 1'b0;
    endtask

    task automatic checkResults(input string tag, input int expV, input int expH, input int expDc,
                                input int expMode, input int expBest, input int expDone);
        checkOutput({tag, " done cycle"}, doneCycle, expDone);
        checkOutput({tag, " busy at done"}, 32'(busyAtDone), 32'd0);
        checkOutput({tag, " sad_v"}, 32'(sad_v), expV);
        checkOutput({tag, " sad_h"}, 32'(sad_h), expH);
        checkOutput({tag, " sad_dc"}, 32'(sad_dc), expDc);
        checkOutput({tag, " best_mode"}, 32'(best_mode), expMode);
        checkOutput({tag, " best_sad"}, 32'(best_sad), expBest);
        @(posedge clk); #1;
        checkOutput({tag, " done one cycle"}, 32'(done), 32'd0);
    endtask

    initial begin
        reset      = 1'b0;
        start      = 1'b0;
        orig_valid = 1'b0;
        for (int i = 0; i < 16; i++) orig_row[i] = 8'd0;
        setPattern(1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset orig_ready", 32'(orig_ready), 32'd0);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset done", 32'(done), 32'd0);
        checkOutput("reset sad_v", 32'(sad_v), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        $display("[TB] pattern 1: vertical match");
        setPattern(1);
        applyStimulus(0, 0, 0, doneCycle, busyAtDone);
        checkResults("p1", 0, 19200, 10240, 0, 0, 18);

        $display("[TB] pattern 2: horizontal match");
        setPattern(2);
        applyStimulus(0, 0, 0, doneCycle, busyAtDone);
        checkResults("p2", 15360, 0, 8192, 1, 0, 18);

        $display("[TB] pattern 3: flat block, three-way tie");
        setPattern(3);
        applyStimulus(0, 0, 0, doneCycle, busyAtDone);
        checkResults("p3", 0, 0, 0, 0, 0, 18);

        $display("[TB] pattern 4: worst-case SAD");
        setPattern(4);
        applyStimulus(0, 0, 0, doneCycle, busyAtDone);
        checkResults("p4", 65280, 65280, 0, 2, 0, 18);

        $display("[TB] pattern 5: H/DC tie");
        setPattern(5);
        applyStimulus(0, 0, 0, doneCycle, busyAtDone);
        checkResults("p5", 5120, 2560, 2560, 1, 2560, 18);

        $display("[TB] pattern 1 gapped, second start, predictions changed mid-run");
        setPattern(1);
        applyStimulus(1, 1, 1, doneCycle, busyAtDone);
        checkResults("p1gap", 0, 19200, 10240, 0, 0, 33);

        $display("[TB] abort by reset after row 7");
        setPattern(2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        checkOutput("held sad_h on start", 32'(sad_h), 32'd19200);
        checkOutput("ready in accum", 32'(orig_ready), 32'd1);
        for (int r = 0; r < 8; r++) begin
            orig_valid = 1'b1;
            for (int i = 0; i < 16; i++) orig_row[i] = origMem[r][i];
            @(posedge clk); #1;
        end
        #2;
        reset = 1'b0;
        #1;
        checkOutput("abort orig_ready", 32'(orig_ready), 32'd0);
        checkOutput("abort busy", 32'(busy), 32'd0);
        checkOutput("abort best_mode", 32'(best_mode), 32'd0);
        checkOutput("abort best_sad", 32'(best_sad), 32'd0);
        checkOutput("abort sad_h", 32'(sad_h), 32'd0);
        checkOutput("abort sad_dc", 32'(sad_dc), 32'd0);
        orig_valid = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        reset    = 1'b1;
        doneSeen = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk); #1;
            if (done !== 1'b0) doneSeen++;
        end
        checkOutput("no done after abort", doneSeen, 0);

        $display("[TB] fresh run after abort");
        setPattern(2);
        applyStimulus(0, 0, 0, doneCycle, busyAtDone);
        checkResults("p2again", 15360, 0, 8192, 1, 0, 18);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
